alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
Upstream feeder for the 16-bit ALU. Accepts ALU commands over a valid/ready port and buffers them in a small FIFO. Issues one command at a time onto the ALU input bus, waits a configurable ALU latency, then captures result/carry_out and returns them on a valid/ready response port. An optional carry-chain mode lets multi-word arithmetic be sequenced without the host tracking carry.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, minimum 2
ALU_LAT, 1, clk edges from stable ALU inputs to valid alu_result/alu_carry_out; 0 means a combinational ALU

Ports:
clk  in  1  clock; all logic on its rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept; equals !full
cmd_a  in  16  operand A
cmd_b  in  16  operand B
cmd_opcode  in  4  ALU opcode
cmd_mode  in  1  ALU mode bit
cmd_carry_in  in  1  explicit carry in
cmd_chain  in  1  1 = use stored carry from the previous completed op instead of cmd_carry_in
alu_operand_a  out  16  to ALU operand_a
alu_operand_b  out  16  to ALU operand_b
alu_opcode  out  4  to ALU opcode
alu_mode  out  1  to ALU mode
alu_carry_in  out  1  to ALU carry_in
alu_result  in  16  from ALU result
alu_carry_out  in  1  from ALU carry_out
rsp_valid  out  1  response held
rsp_ready  in  1  consumer accepts response
rsp_result  out  16  captured result
rsp_carry  out  1  captured carry_out
busy  out  1  1 when state != IDLE or FIFO non-empty

Behaviour:
- Reset (reset=0, async): FIFO empty, state IDLE, all alu_* outputs 0, rsp_valid/rsp_result/rsp_carry 0, carry_reg 0, lat_cnt 0. Asserting reset mid-operation drops the in-flight op and all queued commands. No response is produced for them.
- FIFO: push on cmd_valid && cmd_ready. Each entry stores {a, b, opcode, mode, carry_in, chain}. The pointers wrap modulo DEPTH, and a separate count distinguishes full from empty. cmd_ready is low when full, even if a pop occurs in the same cycle (no full-bypass). Simultaneous push and pop with 0 < count < DEPTH leaves count unchanged.
- FSM states:
  - IDLE: if FIFO non-empty, pop at the edge and register the alu_* outputs from the head entry. alu_carry_in takes carry_reg if chain=1, otherwise carry_in. Load lat_cnt = ALU_LAT and go to WAIT. If the FIFO is empty, stay in IDLE.
  - WAIT: if lat_cnt == 0, capture alu_result into rsp_result and alu_carry_out into rsp_carry and carry_reg, set rsp_valid=1, and go to RESP. Otherwise decrement lat_cnt.
  - RESP: hold rsp_* stable while rsp_valid && !rsp_ready. On rsp_ready, clear rsp_valid and go to IDLE.
- alu_* outputs hold their last issued values outside ISSUE/WAIT; they change only at a pop edge.
- Latency, for ALU_LAT=1 with an empty FIFO in IDLE: command accepted at edge E → pop at E+1 → capture at E+3 → rsp_valid high after E+3. In general, capture occurs at E+2+ALU_LAT.
- Throughput: one op per ALU_LAT+3 cycles when rsp_ready is held high. Commands keep queuing during WAIT and RESP.
- carry_reg updates only on capture. A chained first op after reset uses 0.

Optional Feature:
ALU_SEQ_STATS_EN
- Defined: adds output op_count (16 bits), which increments on every rsp handshake, wraps 0xFFFF→0x0000, and resets to 0. Also adds output overflow_seen (1 bit), which is sticky-set when a push is attempted while full (cmd_valid && !cmd_ready) and cleared only by reset.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
Bench ALU stub (ALU_LAT=1) registers result = a+b+carry_in and carry_out = bit 16 of the sum.
1. Single op: a=0x1234, b=0x0001, carry_in=0 → alu_operand_a=0x1234 one edge after accept; rsp_valid after E+3 with rsp_result=0x1235, rsp_carry=0; busy falls after the handshake.
2. Carry chain: op1 a=0xFFFF, b=0x0001, chain=0 → rsp 0x0000, carry 1. Then op2 a=0x0000, b=0x0000, chain=1, carry_in=0 → alu_carry_in=1, rsp 0x0001, carry 0.
3. Back-pressure: rsp_ready=0, push 6 commands → first accepted op sits in RESP and cmd_ready drops after DEPTH further pushes. Release rsp_ready → all responses arrive in push order with correct sums.
4. Response stall: hold rsp_ready=0 for 10 cycles → rsp_valid, rsp_result and rsp_carry are stable throughout, and no new alu_* value is issued.
5. Reset mid-WAIT: assert reset one cycle after a pop with 2 commands still queued → all outputs 0 immediately (async). After release, with no new commands, rsp_valid never rises and busy=0.
6. ALU_SEQ_STATS_EN: preload 0xFFFF completions (force or long run), then one more handshake → op_count=0x0000. Push while full → overflow_seen=1 and it stays set.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command FIFO plus a three-state issue/wait/respond sequencer
// that feeds a 16-bit ALU and returns its result over a valid/ready port.
// Optional macro ALU_SEQ_STATS_EN adds the op_count and overflow_seen outputs.
module alu_op_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic [3:0]  cmd_opcode,
  input  logic        cmd_mode,
  input  logic        cmd_carry_in,
  input  logic        cmd_chain,
  output logic [15:0] alu_operand_a,
  output logic [15:0] alu_operand_b,
  output logic [3:0]  alu_opcode,
  output logic        alu_mode,
  output logic        alu_carry_in,
  input  logic [15:0] alu_result,
  input  logic        alu_carry_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_carry,
  output logic        busy
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0] op_count,
  output logic        overflow_seen
`endif
);

  localparam int unsigned PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LAT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ALU_LAT);

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  opcode;
    logic        mode;
    logic        carry_in;
    logic        chain;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  // FIFO storage and bookkeeping
  cmd_t             mem_q [DEPTH];
  cmd_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Sequencer state and registered outputs
  state_t           state_q, state_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic             carry_reg_q, carry_reg_d;
  logic [15:0]      alu_a_q, alu_a_d;
  logic [15:0]      alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic             alu_mode_q, alu_mode_d;
  logic             alu_cin_q, alu_cin_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [15:0]      rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;

  logic push;
  logic pop;
  cmd_t head;
  cmd_t entry_in;

  assign cmd_ready = (count_q != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign head      = mem_q[rd_ptr_q];

  assign entry_in.a        = cmd_a;
  assign entry_in.b        = cmd_b;
  assign entry_in.opcode   = cmd_opcode;
  assign entry_in.mode     = cmd_mode;
  assign entry_in.carry_in = cmd_carry_in;
  assign entry_in.chain    = cmd_chain;

  // FIFO next-state: write on push, advance read pointer on pop, track occupancy
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = entry_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sequencer next-state: issue head entry, count down ALU latency, hold response
  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    carry_reg_d  = carry_reg_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_mode_d   = alu_mode_q;
    alu_cin_d    = alu_cin_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          alu_a_d    = head.a;
          alu_b_d    = head.b;
          alu_op_d   = head.opcode;
          alu_mode_d = head.mode;
          // chained ops take the carry left by the last completed op
          alu_cin_d  = head.chain ? carry_reg_q : head.carry_in;
          lat_cnt_d  = LAT_INIT;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_cnt_q == '0) begin
          rsp_result_d = alu_result;
          rsp_carry_d  = alu_carry_out;
          carry_reg_d  = alu_carry_out;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer registers, including all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      lat_cnt_q    <= '0;
      carry_reg_q  <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      alu_mode_q   <= 1'b0;
      alu_cin_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      carry_reg_q  <= carry_reg_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_mode_q   <= alu_mode_d;
      alu_cin_q    <= alu_cin_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
    end
  end

  assign alu_operand_a = alu_a_q;
  assign alu_operand_b = alu_b_q;
  assign alu_opcode    = alu_op_q;
  assign alu_mode      = alu_mode_q;
  assign alu_carry_in  = alu_cin_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_carry     = rsp_carry_q;
  assign busy          = (state_q != S_IDLE) || (count_q != '0);

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] op_count_q, op_count_d;
  logic        overflow_q, overflow_d;

  // Completed-handshake counter (wrapping) and sticky push-while-full flag
  always_comb begin
    op_count_d = op_count_q;
    overflow_d = overflow_q;
    if (rsp_valid_q && rsp_ready) begin
      op_count_d = op_count_q + 16'd1;
    end
    if (cmd_valid && !cmd_ready) begin
      overflow_d = 1'b1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      op_count_q <= op_count_d;
      overflow_q <= overflow_d;
    end
  end

  assign op_count      = op_count_q;
  assign overflow_seen = overflow_q;
`endif

endmodule
